audio_adsr: RTL

- ADSR envelope stage sitting directly downstream of the wave generators (audio_saw and siblings).
- Consumes the generator's unsigned 8-bit sample stream and scales its amplitude around mid-scale 0x80 by an 8-bit envelope.
- The envelope is driven by a gate input through an Attack/Decay/Sustain/Release FSM.
- The output is unsigned 8-bit, the same format as the generator, so it drops into the existing 48 kHz WAV capture path unchanged.

---
 rtl/audio_adsr.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_adsr.sv
// -----------------------------------------------------------------------------
// audio_adsr
//
// ADSR envelope stage for the unsigned 8-bit wave generators. A gate input
// drives an Attack/Decay/Sustain/Release state machine that moves a 16-bit
// envelope accumulator once per envelope tick. The top byte of the
// accumulator scales the incoming sample around mid-scale 0x80. The output
// keeps the generator's unsigned 8-bit format.
//
// Parameters
//   TICK_DIV      envelope update divider, one tick every TICK_DIV+1 clocks
//
// Ports
//   clk_i         system clock
//   rstn_i        synchronous active-low reset
//   gate_i        note gate, level-sensitive, 1 = key held
//   sample_data_i unsigned wave sample, mid-scale 0x80
//   attack_i      attack step per tick, 0 = instant
//   decay_i       decay step per tick, 0 = instant
//   sustain_i     sustain level (upper byte of the accumulator target)
//   release_i     release step per tick, 0 = instant
//   sample_data_o enveloped sample, registered, one clock after sample_data_i
//   env_o         current envelope level (accumulator upper byte)
//   busy_o        1 whenever the state machine is not idle
// -----------------------------------------------------------------------------
module audio_adsr #(
  parameter int unsigned TICK_DIV = 259
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       gate_i,
  input  logic [7:0] sample_data_i,
  input  logic [7:0] attack_i,
  input  logic [7:0] decay_i,
  input  logic [7:0] sustain_i,
  input  logic [7:0] release_i,
  output logic [7:0] sample_data_o,
  output logic [7:0] env_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV);
  localparam logic [15:0] ACC_FULL  = 16'hFFFF;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gate_q;
  logic [7:0]  sample_q, sample_d;

  logic        tick;
  logic        rise;
  logic        fall;
  logic [15:0] sus_lvl;
  logic [16:0] att_sum;
  logic signed [16:0] dec_diff;
  logic [15:0] rel_diff;

  logic signed [16:0] smp_s;
  logic signed [16:0] env_s;
  logic signed [16:0] prod_s;

  assign tick    = (cnt_q == TICK_LAST);
  assign rise    = gate_i & ~gate_q;
  assign fall    = ~gate_i & gate_q;
  assign sus_lvl = {sustain_i, 8'h00};

  // Widened arithmetic so the saturation compares see the carry / borrow.
  assign att_sum  = {1'b0, acc_q} + {9'd0, attack_i};
  assign dec_diff = $signed({1'b0, acc_q}) - $signed({9'd0, decay_i});
  assign rel_diff = acc_q - {8'd0, release_i};

  // State, accumulator, tick counter, gate history and output sample registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= 16'h0000;
      cnt_q    <= 16'h0000;
      gate_q   <= 1'b0;
      sample_q <= 8'h80;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_i;
      sample_q <= sample_d;
    end
  end

  // Free-running envelope tick divider, 0..TICK_DIV.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (tick) begin
      cnt_d = 16'h0000;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Next state and accumulator update. Gate edges take priority over any
  // tick step in the same cycle, so a transition edge never also moves acc.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        acc_d = 16'h0000;
        if (rise) begin
          state_d = ST_ATTACK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ATTACK: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (attack_i == 8'd0) begin
          acc_d   = ACC_FULL;
          state_d = ST_DECAY;
        end else if (tick) begin
          if (att_sum >= {1'b0, ACC_FULL}) begin
            acc_d   = ACC_FULL;
            state_d = ST_DECAY;
          end else begin
            acc_d = att_sum[15:0];
          end
        end else begin
          state_d = ST_ATTACK;
        end
      end

      ST_DECAY: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (decay_i == 8'd0) begin
          acc_d   = sus_lvl;
          state_d = ST_SUSTAIN;
        end else if (tick) begin
          // Signed compare: a step below zero also lands on the sustain level.
          if (dec_diff <= $signed({1'b0, sus_lvl})) begin
            acc_d   = sus_lvl;
            state_d = ST_SUSTAIN;
          end else begin
            acc_d = dec_diff[15:0];
          end
        end else begin
          state_d = ST_DECAY;
        end
      end

      ST_SUSTAIN: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else begin
          // Follow live sustain_i changes every cycle.
          acc_d = sus_lvl;
        end
      end

      ST_RELEASE: begin
        if (rise) begin
          // Retrigger: attack resumes from the current level.
          state_d = ST_ATTACK;
        end else if (release_i == 8'd0) begin
          acc_d   = 16'h0000;
          state_d = ST_IDLE;
        end else if (tick) begin
          if (acc_q <= {8'd0, release_i}) begin
            acc_d   = 16'h0000;
            state_d = ST_IDLE;
          end else begin
            acc_d = rel_diff;
          end
        end else begin
          state_d = ST_RELEASE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        acc_d   = 16'h0000;
      end
    endcase
  end

  // Amplitude scaling around mid-scale: 128 + ((sample - 128) * env) >>> 8.
  // The result spans 0x00..0xFE, so the low byte of the sum is exact.
  always_comb begin
    smp_s    = $signed({9'd0, sample_data_i}) - 17'sd128;
    env_s    = $signed({9'd0, acc_q[15:8]});
    prod_s   = smp_s * env_s;
    sample_d = 8'((prod_s >>> 8) + 17'sd128);
  end

  assign sample_data_o = sample_q;
  assign env_o         = acc_q[15:8];
  assign busy_o        = (state_q != ST_IDLE);

endmodule
